// File: rtl/ts_multi_pid_capture.sv
// MPEG-TS multi-PID packet capture: 0x47 sync hunter, NUM_PIDS PID slots,
// two-bank ping-pong packet buffer read through an indexed word port.
module ts_multi_pid_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_PIDS           = 8,
  parameter int PACK_BYTE_SIZE     = 188,
  localparam int BPW            = C_S_AXI_DATA_WIDTH / 8,
  localparam int IDX_W          = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1,
  localparam int PACK_WORD_SIZE = (PACK_BYTE_SIZE + BPW - 1) / BPW,
  localparam int WA_W           = $clog2(PACK_WORD_SIZE)
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          pid_wr_en,
  input  logic [IDX_W-1:0]              pid_wr_index,
  input  logic [31:0]                   pid_wr_data,
  input  logic [IDX_W-1:0]              pid_rd_index,
  output logic [31:0]                   pid_rd_data,
  input  logic                          filter_enable,
  input  logic [7:0]                    ts_data,
  input  logic                          ts_valid,
  input  logic                          ts_sync,
  output logic                          pkt_ready,
  output logic [IDX_W-1:0]              pkt_slot,
  input  logic [WA_W-1:0]               rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  input  logic                          pkt_release,
  output logic [31:0]                   drop_count
);
  localparam int DW         = C_S_AXI_DATA_WIDTH;
  localparam int LANE_W     = $clog2(BPW);
  localparam int CNT_W      = $clog2(PACK_BYTE_SIZE + 1);
  localparam int LAST_BYTES = PACK_BYTE_SIZE - (PACK_WORD_SIZE - 1) * BPW;
  // Lanes past the final packet byte are never written; mask them on read.
  localparam logic [DW-1:0] LAST_MASK = {DW{1'b1}} >> (8 * (BPW - LAST_BYTES));

  typedef enum logic [1:0] {HUNT, HDR, CAP} state_t;

  logic [12:0]         slot_pid [NUM_PIDS];
  logic [NUM_PIDS-1:0] slot_en;
  logic [DW-1:0]       mem [2][PACK_WORD_SIZE];

  state_t           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       b1, b1_n;
  logic [IDX_W-1:0] cur_slot, slot_n;
  logic [1:0]       full;
  logic             fill_bank, read_bank;
  logic [IDX_W-1:0] bank_slot [2];

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [12:0]      pid;
  logic             we, done, drop;
  logic [WA_W-1:0]  wa;
  logic [BPW-1:0]   wbe;
  logic [DW-1:0]    wd;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{pid_wr_data[31:17], pid_wr_data[15:13]};

  assign pkt_ready = full[read_bank];
  assign pkt_slot  = bank_slot[read_bank];
  assign pid       = {b1[4:0], ts_data};

  // Slot table write and registered read-back.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_PIDS; i++) slot_pid[i] <= '0;
      slot_en     <= '0;
      pid_rd_data <= '0;
    end else begin
      if (pid_wr_en && 32'(pid_wr_index) < NUM_PIDS) begin
        slot_pid[pid_wr_index] <= pid_wr_data[12:0];
        slot_en[pid_wr_index]  <= pid_wr_data[16];
      end
      if (32'(pid_rd_index) < NUM_PIDS)
        pid_rd_data <= {15'b0, slot_en[pid_rd_index], 3'b0, slot_pid[pid_rd_index]};
      else
        pid_rd_data <= '0;
    end
  end

  // Lowest-index enabled slot whose PID equals the header PID wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PIDS - 1; i >= 0; i--)
      if (slot_en[i] && slot_pid[i] == pid) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end

  // Packet FSM next state and buffer write port; a sync byte outside HUNT
  // abandons the current packet and is re-examined as a fresh start.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    b1_n   = b1;
    slot_n = cur_slot;
    we     = 1'b0;
    wa     = '0;
    wbe    = '0;
    wd     = {BPW{ts_data}};
    done   = 1'b0;
    drop   = 1'b0;
    if (ts_valid) begin
      if (st == HUNT || ts_sync) begin
        st_n  = HUNT;
        cnt_n = '0;
        if (ts_sync && ts_data == 8'h47 && filter_enable) begin
          st_n  = HDR;
          cnt_n = CNT_W'(1);
        end
      end else if (st == HDR) begin
        if (cnt == CNT_W'(1)) begin
          b1_n  = ts_data;
          cnt_n = CNT_W'(2);
        end else if (!hit) begin
          st_n = HUNT;
        end else if (full[fill_bank]) begin
          drop = 1'b1;
          st_n = HUNT;
        end else begin
          // Header bytes 0..2 land in word 0 together once the bank is known free.
          we       = 1'b1;
          wbe[2:0] = 3'b111;
          wd[7:0]  = 8'h47;
          wd[15:8] = b1;
          slot_n   = hit_idx;
          st_n     = CAP;
          cnt_n    = CNT_W'(3);
        end
      end else begin
        we                   = 1'b1;
        wa                   = WA_W'(cnt >> LANE_W);
        wbe[cnt[LANE_W-1:0]] = 1'b1;
        cnt_n                = cnt + 1'b1;
        if (cnt == CNT_W'(PACK_BYTE_SIZE - 1)) begin
          done  = 1'b1;
          st_n  = HUNT;
          cnt_n = '0;
        end
      end
    end
  end

  // FSM registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      st       <= HUNT;
      cnt      <= '0;
      b1       <= '0;
      cur_slot <= '0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      b1       <= b1_n;
      cur_slot <= slot_n;
    end
  end

  // Byte-lane writes into the fill bank.
  always_ff @(posedge S_AXI_ACLK) begin
    for (int j = 0; j < BPW; j++)
      if (we && wbe[j]) mem[fill_bank][wa][8*j +: 8] <= wd[8*j +: 8];
  end

  // Bank ownership, drop counter and registered read port. Completion and
  // release never target the same bank, so both may act in one cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      full       <= '0;
      fill_bank  <= 1'b0;
      read_bank  <= 1'b0;
      bank_slot[0] <= '0;
      bank_slot[1] <= '0;
      drop_count <= '0;
      rd_data    <= '0;
    end else begin
      if (done) begin
        full[fill_bank]      <= 1'b1;
        bank_slot[fill_bank] <= cur_slot;
        fill_bank            <= ~fill_bank;
      end
      if (pkt_release && full[read_bank]) begin
        full[read_bank] <= 1'b0;
        read_bank       <= ~read_bank;
      end
      if (drop && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      if (32'(rd_addr) < PACK_WORD_SIZE - 1)
        rd_data <= mem[read_bank][rd_addr];
      else if (32'(rd_addr) == PACK_WORD_SIZE - 1)
        rd_data <= mem[read_bank][rd_addr] & LAST_MASK;
      else
        rd_data <= '0;
    end
  end
endmodule

// File: tb/tb_ts_multi_pid_capture.sv
// Bench for ts_multi_pid_capture: 32-bit and 64-bit instances fed the same
// stream; expected packets queued at send time and compared on readout.
module tb_ts_multi_pid_capture;
  logic        clk = 0, rst_n = 0;
  logic        pid_wr_en = 0;
  logic [2:0]  pid_wr_index = 0, pid_rd_index = 0;
  logic [31:0] pid_wr_data = 0, pid_rd_data, pid_rd_data64;
  logic        filter_enable = 1, ts_valid = 0, ts_sync = 0, pkt_release = 0;
  logic [7:0]  ts_data = 0;
  logic        pkt_ready, pkt_ready64;
  logic [2:0]  pkt_slot, pkt_slot64;
  logic [5:0]  rd_addr = 0;
  logic [4:0]  rd_addr64 = 0;
  logic [31:0] rd_data, drop_count, drop_count64;
  logic [63:0] rd_data64;

  int checks = 0, errors = 0;

  typedef struct { int slot; int pid; int seed; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  ts_multi_pid_capture #(.C_S_AXI_DATA_WIDTH(32)) u32 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .pid_wr_en(pid_wr_en),
    .pid_wr_index(pid_wr_index), .pid_wr_data(pid_wr_data), .pid_rd_index(pid_rd_index),
    .pid_rd_data(pid_rd_data), .filter_enable(filter_enable), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_sync(ts_sync), .pkt_ready(pkt_ready), .pkt_slot(pkt_slot),
    .rd_addr(rd_addr), .rd_data(rd_data), .pkt_release(pkt_release), .drop_count(drop_count));

  ts_multi_pid_capture #(.C_S_AXI_DATA_WIDTH(64)) u64 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .pid_wr_en(pid_wr_en),
    .pid_wr_index(pid_wr_index), .pid_wr_data(pid_wr_data), .pid_rd_index(pid_rd_index),
    .pid_rd_data(pid_rd_data64), .filter_enable(filter_enable), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_sync(ts_sync), .pkt_ready(pkt_ready64), .pkt_slot(pkt_slot64),
    .rd_addr(rd_addr64), .rd_data(rd_data64), .pkt_release(pkt_release), .drop_count(drop_count64));

  function automatic logic [7:0] gen(int pid, int seed, int k);
    if (k == 0) return 8'h47;
    if (k == 1) return 8'h40 | 8'((pid >> 8) & 31);
    if (k == 2) return 8'(pid & 255);
    return 8'((k + seed) & 255);
  endfunction

  function automatic logic [63:0] word_exp(int pid, int seed, int bpw, int w);
    logic [63:0] r = '0;
    for (int j = 0; j < bpw; j++)
      if (w * bpw + j < 188) r[8*j +: 8] = gen(pid, seed, w * bpw + j);
    return r;
  endfunction

  task automatic write_slot(int idx, logic [31:0] d);
    @(negedge clk);
    pid_wr_en = 1; pid_wr_index = 3'(idx); pid_wr_data = d;
    @(negedge clk);
    pid_wr_en = 0;
  endtask

  // Bytes [from, to) of a packet; byte 0 carries ts_sync.
  task automatic send_range(int pid, int seed, int gap, int from, int to);
    for (int k = from; k < to; k++) begin
      ts_valid = 1; ts_sync = (k == 0); ts_data = gen(pid, seed, k);
      @(negedge clk);
      ts_valid = 0; ts_sync = 0; ts_data = 8'hA5;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic check_pkt();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: got 0 entries, required >=1");
      return;
    end
    e = q.pop_front();
    checks++;
    if (pkt_ready !== 1'b1 || pkt_ready64 !== 1'b1) begin
      errors++; $display("FAIL pkt_ready: got %b/%b required 1/1", pkt_ready, pkt_ready64);
    end
    checks++;
    if (pkt_slot !== 3'(e.slot) || pkt_slot64 !== 3'(e.slot)) begin
      errors++; $display("FAIL pkt_slot: got %0d/%0d required %0d", pkt_slot, pkt_slot64, e.slot);
    end
    for (int w = 0; w < 47; w++) begin
      rd_addr = 6'(w); rd_addr64 = 5'(w < 24 ? w : 0);
      @(negedge clk);
      checks++;
      if (rd_data !== word_exp(e.pid, e.seed, 4, w)) begin
        errors++;
        $display("FAIL rd_data32 w%0d: got %h required %h", w, rd_data, word_exp(e.pid, e.seed, 4, w));
      end
      if (w < 24) begin
        checks++;
        if (rd_data64 !== word_exp(e.pid, e.seed, 8, w)) begin
          errors++;
          $display("FAIL rd_data64 w%0d: got %h required %h", w, rd_data64, word_exp(e.pid, e.seed, 8, w));
        end
      end
    end
    pkt_release = 1;
    @(negedge clk);
    pkt_release = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (pkt_ready !== 0 || pkt_slot !== 0 || rd_data !== 0 || drop_count !== 0 ||
        pid_rd_data !== 0 || rd_data64 !== 0 || pkt_ready64 !== 0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b slot=%0d rd=%h drop=%0d pidrd=%h required all 0",
               pkt_ready, pkt_slot, rd_data, drop_count, pid_rd_data);
    end
  endtask

  task automatic test_slots();
    write_slot(3, 32'h0001_0100);
    write_slot(5, 32'hABCD_FFFF);
    pid_rd_index = 3; @(negedge clk);
    checks++;
    if (pid_rd_data !== 32'h0001_0100) begin
      errors++; $display("FAIL slot3_readback: got %h required 00010100", pid_rd_data);
    end
    pid_rd_index = 5; @(negedge clk);
    checks++;
    if (pid_rd_data !== 32'h0001_1FFF) begin
      errors++; $display("FAIL slot5_readback: got %h required 00011fff", pid_rd_data);
    end
  endtask

  task automatic test_basic();
    send_range(12'h100, 0, 0, 0, 187);
    checks++;
    if (pkt_ready !== 0) begin
      errors++; $display("FAIL early_ready: got %b required 0", pkt_ready);
    end
    q.push_back('{3, 12'h100, 0});
    send_range(12'h100, 0, 0, 187, 188);
    check_pkt();
  endtask

  task automatic test_priority();
    write_slot(1, 32'h0001_1FFF);
    send_range(13'h1FFF, 9, 0, 0, 188);
    q.push_back('{1, 13'h1FFF, 9});
    check_pkt();
    write_slot(1, 32'h0000_1FFF);
    send_range(13'h1FFF, 11, 0, 0, 188);
    q.push_back('{5, 13'h1FFF, 11});
    check_pkt();
    send_range(13'h0011, 0, 0, 0, 188);
    checks++;
    if (pkt_ready !== 0) begin
      errors++; $display("FAIL nomatch_capture: got pkt_ready=%b required 0", pkt_ready);
    end
  endtask

  task automatic test_overflow();
    for (int s = 1; s <= 3; s++) begin
      send_range(12'h100, s, 0, 0, 188);
      if (s < 3) q.push_back('{3, 12'h100, s});
    end
    checks++;
    if (drop_count !== 1 || drop_count64 !== 1) begin
      errors++; $display("FAIL drop_count: got %0d/%0d required 1", drop_count, drop_count64);
    end
    check_pkt();
    check_pkt();
    checks++;
    if (pkt_ready !== 0) begin
      errors++; $display("FAIL drained_ready: got %b required 0", pkt_ready);
    end
  endtask

  task automatic test_sync_loss();
    send_range(12'h100, 40, 0, 0, 100);
    send_range(12'h100, 5, 0, 0, 188);
    q.push_back('{3, 12'h100, 5});
    check_pkt();
    checks++;
    if (pkt_ready !== 0) begin
      errors++; $display("FAIL sync_loss_extra: got pkt_ready=%b required 0", pkt_ready);
    end
  endtask

  task automatic test_gaps();
    send_range(12'h100, 0, 3, 0, 188);
    q.push_back('{3, 12'h100, 0});
    check_pkt();
  endtask

  task automatic test_filter();
    filter_enable = 0;
    send_range(12'h100, 20, 0, 0, 188);
    checks++;
    if (pkt_ready !== 0) begin
      errors++; $display("FAIL filter_off_start: got pkt_ready=%b required 0", pkt_ready);
    end
    filter_enable = 1;
    send_range(12'h100, 21, 0, 0, 10);
    filter_enable = 0;
    send_range(12'h100, 21, 0, 10, 188);
    q.push_back('{3, 12'h100, 21});
    check_pkt();
    filter_enable = 1;
  endtask

  task automatic test_async_reset();
    // leave drop_count nonzero, one bank full, then reset mid-capture
    send_range(12'h100, 30, 0, 0, 188);
    send_range(12'h100, 31, 0, 0, 188);
    send_range(12'h100, 32, 0, 0, 188);
    send_range(12'h100, 33, 0, 0, 60);
    rd_addr = 1; pid_rd_index = 3;
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if (pkt_ready !== 0 || pkt_slot !== 0 || rd_data !== 0 || drop_count !== 0 ||
        pid_rd_data !== 0 || pkt_ready64 !== 0 || rd_data64 !== 0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b slot=%0d rd=%h drop=%0d pidrd=%h required all 0",
               pkt_ready, pkt_slot, rd_data, drop_count, pid_rd_data);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (pid_rd_data !== 0) begin
      errors++; $display("FAIL slot_cleared: got %h required 0", pid_rd_data);
    end
    write_slot(2, 32'h0001_0100);
    send_range(12'h100, 50, 0, 0, 188);
    q.push_back('{2, 12'h100, 50});
    check_pkt();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_slots();
    test_basic();
    test_priority();
    test_overflow();
    test_sync_loss();
    test_gaps();
    test_filter();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ts_multi_pid_capture.md
Name: ts_multi_pid_capture

Overview:
Next-generation MPEG-TS PID monitor with several PID filter slots instead of one.
- Hunts 0x47-synchronised 188-byte packets on a byte stream in the S_AXI_ACLK domain.
- Matches the 13-bit PID against NUM_PIDS programmable slots.
- Stores matched packets in a two-bank ping-pong buffer, read by the AXI register block through an indexed word port with an explicit release handshake.
- Adds parametrised word width, slot-index reporting, sync-loss abort and overflow counting.

Parameters:
C_S_AXI_DATA_WIDTH, 32, read-port word width; 32 or 64. BPW = C_S_AXI_DATA_WIDTH/8.
NUM_PIDS, 8, number of PID filter slots (1..32). IDX_W = max(1, clog2(NUM_PIDS)).
PACK_BYTE_SIZE, 188, TS packet length in bytes.
PACK_WORD_SIZE, ceil(PACK_BYTE_SIZE/BPW), derived words per bank. 47 for 32-bit, 24 for 64-bit. WA_W = clog2(PACK_WORD_SIZE).

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
pid_wr_en  in  1  write pid_wr_data into slot pid_wr_index
pid_wr_index  in  IDX_W  slot to write
pid_wr_data  in  32  [12:0] PID, [16] slot enable, other bits ignored
pid_rd_index  in  IDX_W  slot to read back
pid_rd_data  out  32  registered {15'b0, en, 3'b0, pid}
filter_enable  in  1  global capture enable
ts_data  in  8  stream byte
ts_valid  in  1  ts_data/ts_sync qualified this cycle
ts_sync  in  1  marks first byte of a packet
pkt_ready  out  1  read bank holds a complete packet
pkt_slot  out  IDX_W  slot that matched the packet in the read bank
rd_addr  in  WA_W  word index into the read bank
rd_data  out  C_S_AXI_DATA_WIDTH  word at rd_addr, 1-cycle latency
pkt_release  in  1  one-cycle pulse: read bank consumed
drop_count  out  32  matched packets lost for lack of a free bank, saturating

Behaviour:
- Reset (asynchronous assert, any time including mid-packet):
  - All slots cleared (pid=0, en=0). pid_rd_data=0. rd_data=0. pkt_ready=0. pkt_slot=0. drop_count=0.
  - Both banks empty. fill_bank=0, read_bank=0. FSM in HUNT.
- Slot table:
  - pid_wr_en updates the slot on the next edge.
  - pid_rd_data registered, latency 1.
  - An index >= NUM_PIDS is ignored on write and reads back 0.
- Byte packing: packet byte i goes to word i/BPW, bits [8*(i%BPW)+7 : 8*(i%BPW)]. Unused upper bytes of the last word read as 0.
- All FSM actions occur only on cycles with ts_valid=1. ts_valid=0 holds all state.
- FSM states:
  - HUNT: on ts_sync=1 and ts_data=8'h47 and filter_enable=1, write byte 0 into fill_bank if that bank is free, then go to HDR with byte_cnt=1. Otherwise stay in HUNT.
  - HDR: byte 1 is held and written. At byte 2, PID={byte1[4:0], byte2}. Match = lowest-index enabled slot with equal PID; slot values are those current at byte 2.
    - Match and fill_bank free: latch the slot, write byte 2, go to CAPTURE.
    - Match and no free bank: increment drop_count (saturate at 32'hFFFFFFFF), go to HUNT.
    - No match: go to HUNT.
  - CAPTURE: write bytes 3..187. On byte 187 mark fill_bank full, record its slot, toggle fill_bank, go to HUNT.
- Sync loss: ts_sync=1 in HDR or CAPTURE before byte 188 aborts the packet. The bank stays free and is overwritten later. That same byte is evaluated as a HUNT byte in the same cycle.
- filter_enable=0 blocks only new packet starts. A packet already in HDR or CAPTURE completes.
- Read side:
  - pkt_ready = full[read_bank]. pkt_slot is the latched slot of read_bank.
  - pkt_release with pkt_ready=1: clear full[read_bank], toggle read_bank.
  - pkt_release with pkt_ready=0 is ignored.
  - Completion and release in the same cycle both take effect. The second bank's pkt_ready rises the following cycle.
- Ordering: banks are consumed strictly in fill order. At most 2 packets are buffered.

Test Plan:
- Slot 3 = PID 0x0100 enabled; send 188-byte packet 47 41 00 ... (byte k = k for k>=3) -> pkt_ready=1 one cycle after byte 187; pkt_slot=3; rd_addr=0 gives 32'h00_0041_47... i.e. 0x03004147; rd_addr=46 gives 0xBBBAB9B8.
- Slots 1 and 5 both hold PID 0x1FFF, enabled -> pkt_slot=1. Disable slot 1, resend -> pkt_slot=5. Packet with PID 0x0011 -> no capture.
- Three matching packets, no release -> first two buffered, drop_count=1. Release once -> second packet readable, pkt_slot correct.
- ts_sync re-asserted at byte 100 with 0x47 and a matching PID -> first packet discarded, exactly one packet captured from the new sync.
- C_S_AXI_DATA_WIDTH=64: packet captured -> word 23 upper 4 bytes = 0, lower 4 bytes = bytes 184..187. ts_valid gaps of 3 cycles every byte -> identical contents.
- Assert S_AXI_ARESETN low mid-CAPTURE with one bank full -> all outputs 0 asynchronously. The next matching packet lands in bank 0.
